quick_spi_cmd_sequencer: RTL
============================

Name: quick_spi_cmd_sequencer

Overview:
- Command front-end sitting directly upstream of the quick_spi master.
- Accepts SPI commands (slave index, operation, 16-bit payload) from a host bus into a FIFO.
- Issues commands to quick_spi one at a time via start_transaction, waits for end_of_transaction, and returns read data through a valid/ready response port.
- Adds a watchdog that flags transactions which never complete.

Parameters:
- INCOMING_DATA_WIDTH, 8, width of read data returned by quick_spi.
- OUTGOING_DATA_WIDTH, 16, width of write payload passed to quick_spi.
- NUMBER_OF_SLAVES, 2, width of the spi_slave field (carries a binary slave index).
- CMD_FIFO_DEPTH, 4, command FIFO entries; power of two, >=2.
- TIMEOUT_CYCLES, 1024, clk cycles in BUSY before timeout_error sets; must be >=2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset. One clock; no other clock domain.
- cmd_valid  in  1  host presents a command.
- cmd_ready  out  1  FIFO not full.
- cmd_slave  in  NUMBER_OF_SLAVES  target slave index.
- cmd_operation  in  1  0 = READ, 1 = WRITE (same encoding as quick_spi).
- cmd_data  in  OUTGOING_DATA_WIDTH  outgoing payload.
- rsp_valid  out  1  read result held.
- rsp_ready  in  1  host consumes result.
- rsp_data  out  INCOMING_DATA_WIDTH  read result.
- rsp_slave  out  NUMBER_OF_SLAVES  slave index the result came from.
- busy  out  1  command in flight or FIFO non-empty.
- timeout_error  out  1  sticky watchdog flag.
- clear_error  in  1  clears timeout_error.
- spi_start_transaction  out  1  to quick_spi start_transaction.
- spi_slave  out  NUMBER_OF_SLAVES  to quick_spi slave.
- spi_operation  out  1  to quick_spi operation.
- spi_outgoing_data  out  OUTGOING_DATA_WIDTH  to quick_spi outgoing_data.
- spi_end_of_transaction  in  1  from quick_spi.
- spi_incoming_data  in  INCOMING_DATA_WIDTH  from quick_spi.

Behaviour:
- Reset values: all outputs 0 except cmd_ready=1; FIFO emptied; state IDLE; timeout counter 0.
- Command push: occurs when cmd_valid && cmd_ready. cmd_ready = !full, registered-free (combinational from FIFO count). Push while full is ignored.
- FSM states:
  - IDLE: if FIFO non-empty and (head is WRITE or rsp_valid==0), pop head into slave/op/data holding registers and go to ISSUE.
  - ISSUE: spi_start_transaction=1 for exactly this one cycle; go to BUSY.
  - BUSY: count cycles. On spi_end_of_transaction=1:
    - if operation READ, load rsp_data <= spi_incoming_data and rsp_slave, set rsp_valid;
    - go to GAP.
    - Data is sampled in the same cycle end_of_transaction is high, because quick_spi clears it on the next cycle.
  - GAP: one idle cycle so quick_spi can pass WAIT back to IDLE; go to IDLE.
- Minimum command-to-command spacing: ISSUE + BUSY + GAP; no start is issued while quick_spi is outside IDLE.
- spi_slave, spi_operation and spi_outgoing_data are driven from the holding registers and stay stable from ISSUE until leaving GAP. quick_spi reads slave and operation throughout the transfer.
- Response handshake: rsp_valid stays set until rsp_valid && rsp_ready, then clears. A READ is never issued while rsp_valid=1, so results are never overwritten. WRITE commands proceed regardless of rsp_valid.
- Watchdog: the counter increments each BUSY cycle and resets on entering BUSY. When it reaches TIMEOUT_CYCLES-1, timeout_error sets. The FSM keeps waiting in BUSY because recovery is by system reset.
  - clear_error clears the flag.
  - A set and a clear in the same cycle results in set.
- busy = (state != IDLE) || !empty.
- Simultaneous push and pop of the FIFO is allowed, including when full: the pop frees a slot only on the next cycle, so cmd_ready stays low that cycle.
- Reset mid-transaction returns to IDLE and discards the FIFO. The same reset is applied to quick_spi (inverted to its reset_n) by the integrator.
- spi_end_of_transaction outside BUSY is ignored.

Decomposition:
- Shared include/package: READ/WRITE operation encodings, FSM state encodings (IDLE, ISSUE, BUSY, GAP), default widths.
- One sub-module: quick_spi_sync_fifo.
  - Parameterised width and depth; synchronous; active-high reset.
  - Outputs full/empty/count.
  - Stores {slave, operation, data}.

Test Plan:
- Push WRITE slave=1 data=16'hA55A -> spi_start_transaction high exactly one cycle; spi_outgoing_data=16'hA55A and spi_slave=1 held stable until the GAP state; rsp_valid stays 0.
- Push READ slave=0; bench model returns 8'h3C with end_of_transaction -> rsp_valid=1, rsp_data=8'h3C, rsp_slave=0; clears after a rsp_ready handshake.
- Push two READs with rsp_ready=0 -> second start_transaction not issued until the first response is consumed; then rsp_data=second value.
- Push 5 commands back-to-back with the model stalled -> cmd_ready drops after the 4th FIFO entry; all 5 issued in order; start pulses separated by at least one GAP cycle.
- Model never asserts end_of_transaction, TIMEOUT_CYCLES=16 -> timeout_error=1 after 16 BUSY cycles; clear_error drops it; a late end_of_transaction completes normally.
- Assert reset while in BUSY with 3 queued commands -> next cycle all outputs at reset values, busy=0, cmd_ready=1.

Source files
------------

// File: rtl/quick_spi_cmd_sequencer_pkg.sv
// Shared encodings and default widths for the quick_spi command sequencer.
// The operation encoding matches the one quick_spi itself expects.
package quick_spi_cmd_sequencer_pkg;

  localparam int DEF_INCOMING_DATA_WIDTH = 8;
  localparam int DEF_OUTGOING_DATA_WIDTH = 16;
  localparam int DEF_NUMBER_OF_SLAVES    = 2;
  localparam int DEF_CMD_FIFO_DEPTH      = 4;
  localparam int DEF_TIMEOUT_CYCLES      = 1024;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

endpackage

// File: rtl/quick_spi_cmd_sequencer_if.sv
// Host command/response, status and quick_spi-facing signals of the sequencer.
// The slave modport is the sequencer's view; master is the environment's view.
interface quick_spi_cmd_sequencer_if
  import quick_spi_cmd_sequencer_pkg::*;
#(
  parameter int INCOMING_DATA_WIDTH = DEF_INCOMING_DATA_WIDTH,
  parameter int OUTGOING_DATA_WIDTH = DEF_OUTGOING_DATA_WIDTH,
  parameter int NUMBER_OF_SLAVES    = DEF_NUMBER_OF_SLAVES
);

  logic                           cmd_valid;
  logic                           cmd_ready;
  logic [NUMBER_OF_SLAVES-1:0]    cmd_slave;
  logic                           cmd_operation;
  logic [OUTGOING_DATA_WIDTH-1:0] cmd_data;

  logic                           rsp_valid;
  logic                           rsp_ready;
  logic [INCOMING_DATA_WIDTH-1:0] rsp_data;
  logic [NUMBER_OF_SLAVES-1:0]    rsp_slave;

  logic                           busy;
  logic                           timeout_error;
  logic                           clear_error;

  logic                           spi_start_transaction;
  logic [NUMBER_OF_SLAVES-1:0]    spi_slave;
  logic                           spi_operation;
  logic [OUTGOING_DATA_WIDTH-1:0] spi_outgoing_data;
  logic                           spi_end_of_transaction;
  logic [INCOMING_DATA_WIDTH-1:0] spi_incoming_data;

  modport slave (
    input  cmd_valid, cmd_slave, cmd_operation, cmd_data,
    output cmd_ready,
    output rsp_valid, rsp_data, rsp_slave,
    input  rsp_ready,
    output busy, timeout_error,
    input  clear_error,
    output spi_start_transaction, spi_slave, spi_operation, spi_outgoing_data,
    input  spi_end_of_transaction, spi_incoming_data
  );

  modport master (
    output cmd_valid, cmd_slave, cmd_operation, cmd_data,
    input  cmd_ready,
    input  rsp_valid, rsp_data, rsp_slave,
    output rsp_ready,
    input  busy, timeout_error,
    output clear_error,
    input  spi_start_transaction, spi_slave, spi_operation, spi_outgoing_data,
    output spi_end_of_transaction, spi_incoming_data
  );

endinterface

// File: rtl/quick_spi_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with synchronous active-high reset.
// A push while full is dropped; a pop frees its slot only from the next cycle.
module quick_spi_sync_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_wr_en,
  input  logic [WIDTH-1:0]           i_wr_data,
  input  logic                       i_rd_en,
  output logic [WIDTH-1:0]           o_rd_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];
  assign w_push    = i_wr_en && !o_full;
  assign w_pop     = i_rd_en && !o_empty;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/quick_spi_cmd_sequencer.sv
// Queues host SPI commands and issues them to quick_spi one at a time,
// returning read data through a valid/ready port and flagging hung transfers.
module quick_spi_cmd_sequencer
  import quick_spi_cmd_sequencer_pkg::*;
#(
  parameter int INCOMING_DATA_WIDTH = DEF_INCOMING_DATA_WIDTH,
  parameter int OUTGOING_DATA_WIDTH = DEF_OUTGOING_DATA_WIDTH,
  parameter int NUMBER_OF_SLAVES    = DEF_NUMBER_OF_SLAVES,
  parameter int CMD_FIFO_DEPTH      = DEF_CMD_FIFO_DEPTH,
  parameter int TIMEOUT_CYCLES      = DEF_TIMEOUT_CYCLES
) (
  input logic                      clk,
  input logic                      reset,
  quick_spi_cmd_sequencer_if.slave bus
);

  localparam int FIFO_W = NUMBER_OF_SLAVES + 1 + OUTGOING_DATA_WIDTH;
  localparam int WD_W   = $clog2(TIMEOUT_CYCLES + 1);

  state_e                         r_state;
  state_e                         w_state_next;
  logic                           w_pop;

  logic [FIFO_W-1:0]              w_fifo_head;
  logic                           w_fifo_full;
  logic                           w_fifo_empty;
  logic [$clog2(CMD_FIFO_DEPTH):0] w_fifo_count;
  logic [NUMBER_OF_SLAVES-1:0]    w_head_slave;
  op_e                            w_head_op;
  logic [OUTGOING_DATA_WIDTH-1:0] w_head_data;

  logic [NUMBER_OF_SLAVES-1:0]    r_slave;
  op_e                            r_op;
  logic [OUTGOING_DATA_WIDTH-1:0] r_data;
  logic                           r_rsp_valid;
  logic [INCOMING_DATA_WIDTH-1:0] r_rsp_data;
  logic [NUMBER_OF_SLAVES-1:0]    r_rsp_slave;
  logic                           r_timeout_error;
  logic [WD_W-1:0]                r_wd_cnt;
  logic                           w_wd_fire;
  logic                           w_read_done;

  quick_spi_sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (CMD_FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (bus.cmd_valid),
    .i_wr_data ({bus.cmd_slave, bus.cmd_operation, bus.cmd_data}),
    .i_rd_en   (w_pop),
    .o_rd_data (w_fifo_head),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty),
    .o_count   (w_fifo_count)
  );

  assign w_head_slave = w_fifo_head[FIFO_W-1 -: NUMBER_OF_SLAVES];
  assign w_head_op    = op_e'(w_fifo_head[OUTGOING_DATA_WIDTH]);
  assign w_head_data  = w_fifo_head[OUTGOING_DATA_WIDTH-1:0];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A READ waits until the previous result is consumed; WRITEs never block.
        if (!w_fifo_empty && (w_head_op == OP_WRITE || !r_rsp_valid)) begin
          w_pop        = 1'b1;
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: w_state_next = ST_BUSY;
      ST_BUSY:  if (bus.spi_end_of_transaction) w_state_next = ST_GAP;
      ST_GAP:   w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // quick_spi clears end_of_transaction next cycle, so data is captured now.
  assign w_read_done = (r_state == ST_BUSY) && bus.spi_end_of_transaction && (r_op == OP_READ);
  // Counter stops one past the threshold so the flag sets once per transfer.
  assign w_wd_fire   = (r_state == ST_BUSY) && (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_slave         <= '0;
      r_op            <= OP_READ;
      r_data          <= '0;
      r_rsp_valid     <= 1'b0;
      r_rsp_data      <= '0;
      r_rsp_slave     <= '0;
      r_timeout_error <= 1'b0;
      r_wd_cnt        <= '0;
    end else begin
      if (w_pop) begin
        r_slave <= w_head_slave;
        r_op    <= w_head_op;
        r_data  <= w_head_data;
      end

      if (w_read_done) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= bus.spi_incoming_data;
        r_rsp_slave <= r_slave;
      end else if (r_rsp_valid && bus.rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end

      if (r_state == ST_ISSUE) begin
        r_wd_cnt <= '0;
      end else if (r_state == ST_BUSY && r_wd_cnt != WD_W'(TIMEOUT_CYCLES)) begin
        r_wd_cnt <= r_wd_cnt + WD_W'(1);
      end

      if (w_wd_fire)            r_timeout_error <= 1'b1;
      else if (bus.clear_error) r_timeout_error <= 1'b0;
    end
  end

  assign bus.cmd_ready             = !w_fifo_full;
  assign bus.rsp_valid             = r_rsp_valid;
  assign bus.rsp_data              = r_rsp_data;
  assign bus.rsp_slave             = r_rsp_slave;
  assign bus.busy                  = (r_state != ST_IDLE) || (w_fifo_count != '0);
  assign bus.timeout_error         = r_timeout_error;
  assign bus.spi_start_transaction = (r_state == ST_ISSUE);
  assign bus.spi_slave             = r_slave;
  assign bus.spi_operation         = r_op;
  assign bus.spi_outgoing_data     = r_data;

endmodule
